// File: rtl/apple_placer.sv
// Purpose: places a new apple after each good collision by sampling random
//          coordinates, serially scanning the snake body, retrying on a hit and
//          falling back to a deterministic +1 sweep after MAX_TRIES samples.
// Latency: commit 3+body_len cycles after the event pulse when the first
//          candidate is free; each hit adds (hit index + 2) cycles.
// Backpressure: none; one event arriving while busy is held in a one-deep
//          pending flag and further events are dropped.
// Ports: clk/reset (async active-low), goodColl (collision level, async),
//        randX/randY (random candidate), body/body_len (snake segments),
//        x/y (pixel being drawn), apple (registered pixel flag),
//        apple_cord/apple_valid (committed apple), busy, place_done (pulse).
module apple_placer #(
    parameter int         BODY_MAX   = 50,
    parameter int         MAX_TRIES  = 8,
    parameter logic [7:0] RESET_CORD = 8'hC5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     goodColl,
    input  logic [3:0]               randX,
    input  logic [3:0]               randY,
    input  logic [BODY_MAX-1:0][7:0] body,
    input  logic [5:0]               body_len,
    input  logic [3:0]               x,
    input  logic [3:0]               y,
    output logic                     apple,
    output logic [7:0]               apple_cord,
    output logic                     apple_valid,
    output logic                     busy,
    output logic                     place_done
);

    localparam int               TRY_W   = $clog2(MAX_TRIES + 1);
    localparam logic [TRY_W-1:0] TRY_LIM = TRY_W'(MAX_TRIES);

    typedef enum logic [1:0] {IDLE, LOAD, SCAN, COMMIT} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             s1, s2, s3;
    logic             evt;
    logic             pending;
    logic [TRY_W-1:0] tries;
    logic [5:0]       idx;
    logic [7:0]       cand;
    logic             hit;
    logic             start;

    // s1/s2 synchronise the asynchronous level; s3 turns it into a rising-edge pulse
    assign evt  = s2 & ~s3;
    assign hit  = (body[idx] == cand);
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (evt || pending) begin
                    state_nxt = LOAD;
                    start     = 1'b1;
                end
            end
            LOAD: begin
                state_nxt = (body_len == 6'd0) ? COMMIT : SCAN;
            end
            SCAN: begin
                // a hit abandons the rest of the scan and draws a new candidate
                if (hit) begin
                    state_nxt = LOAD;
                end else if (idx == body_len - 6'd1) begin
                    state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            s3          <= 1'b0;
            pending     <= 1'b0;
            tries       <= '0;
            idx         <= '0;
            cand        <= '0;
            apple_cord  <= RESET_CORD;
            apple_valid <= 1'b1;
            apple       <= 1'b0;
            place_done  <= 1'b0;
        end else begin
            s1         <= goodColl;
            s2         <= s1;
            s3         <= s2;
            place_done <= 1'b0;
            apple      <= apple_valid & ({x, y} == apple_cord);

            // leaving IDLE always consumes the pending request; while busy a
            // single event is remembered and any more are dropped
            if (state == IDLE) begin
                pending <= 1'b0;
            end else if (evt) begin
                pending <= 1'b1;
            end

            if (start) begin
                apple_valid <= 1'b0;
            end

            case (state)
                LOAD: begin
                    idx <= '0;
                    if (tries < TRY_LIM) begin
                        cand  <= {randX, randY};
                        tries <= tries + 1'b1;
                    end else begin
                        // random source keeps colliding: walk the board so the
                        // search is bounded (body is always shorter than 256 cells)
                        cand <= cand + 8'd1;
                    end
                end
                SCAN: begin
                    if (!hit) begin
                        idx <= idx + 6'd1;
                    end
                end
                COMMIT: begin
                    apple_cord  <= cand;
                    apple_valid <= 1'b1;
                    place_done  <= 1'b1;
                    tries       <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apple_placer.sv
// Bench for apple_placer: directed placements with a scoreboard of expected
// coordinates and busy-to-done latencies, drained by an independent monitor.
module tb_apple_placer;

    logic             clk;
    logic             reset;
    logic             goodColl;
    logic [3:0]       randX;
    logic [3:0]       randY;
    logic [49:0][7:0] body;
    logic [5:0]       body_len;
    logic [3:0]       x;
    logic [3:0]       y;
    logic             apple;
    logic [7:0]       apple_cord;
    logic             apple_valid;
    logic             busy;
    logic             place_done;

    apple_placer dut (
        .clk         (clk),
        .reset       (reset),
        .goodColl    (goodColl),
        .randX       (randX),
        .randY       (randY),
        .body        (body),
        .body_len    (body_len),
        .x           (x),
        .y           (y),
        .apple       (apple),
        .apple_cord  (apple_cord),
        .apple_valid (apple_valid),
        .busy        (busy),
        .place_done  (place_done)
    );

    typedef struct {
        logic [7:0] cord;
        int         dlat;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   t_drive;
    int   t_busy;
    bit   chk_evt;
    logic busy_prev;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: latency from busy rise, coordinate on place_done, apple_valid while busy
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            busy_prev = 1'b0;
        end else begin
            if (busy && !busy_prev) begin
                t_busy = cyc;
                if (chk_evt) begin
                    chk("event_latency", cyc - t_drive, 3);
                    chk_evt = 1'b0;
                end
            end
            if (busy) chk("valid_low_busy", apple_valid, 0);
            if (place_done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("commit_cord", apple_cord, e.cord);
                    chk("commit_valid", apple_valid, 1);
                    chk("done_latency", cyc - t_busy, e.dlat);
                end
            end
            busy_prev = busy;
        end
    end

    task automatic pulse(input bit first);
        @(negedge clk);
        goodColl = 1'b1;
        if (first) begin
            t_drive = cyc;
            chk_evt = 1'b1;
        end
        @(negedge clk);
        goodColl = 1'b0;
    endtask

    task automatic wait_busy();
        int n;
        n = 0;
        while (!busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!busy) chk("busy_timeout", 0, 1);
    endtask

    task automatic push(input logic [7:0] c, input int d);
        exp_t e;
        e.cord = c;
        e.dlat = d;
        q.push_back(e);
    endtask

    initial begin
        reset    = 1'b0;
        goodColl = 1'b0;
        randX    = 4'h0;
        randY    = 4'h0;
        body     = '0;
        body_len = 6'd0;
        x        = 4'h0;
        y        = 4'h0;
        chk_evt  = 1'b0;
        t_drive  = 0;
        t_busy   = 0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // reset state and apple pixel flag
        chk("rst_cord", apple_cord, 8'hC5);
        chk("rst_valid", apple_valid, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", place_done, 0);
        chk("rst_apple", apple, 0);
        x = 4'hC; y = 4'h5;
        @(negedge clk);
        chk("apple_hit", apple, 1);
        x = 4'hC; y = 4'h4;
        @(negedge clk);
        chk("apple_miss", apple, 0);

        // free cell on first sample: busy at E+1, done at E+6
        body[0] = 8'h11; body[1] = 8'h12; body[2] = 8'h13;
        body_len = 6'd3;
        randX = 4'h7; randY = 4'h2;
        push(8'h72, 5);
        pulse(1);
        repeat (15) @(negedge clk);
        x = 4'h7; y = 4'h2;
        @(negedge clk);
        chk("apple_new", apple, 1);

        // first candidate hits body[1], retry draws 8'h40: done at E+9
        randX = 4'h1; randY = 4'h2;
        push(8'h40, 8);
        pulse(1);
        wait_busy();
        @(negedge clk);
        randX = 4'h4; randY = 4'h0;
        repeat (15) @(negedge clk);

        // random source stuck on body[0]: 8 hits, sweep 12,13 hit, commit 14
        randX = 4'h1; randY = 4'h1;
        push(8'h14, 28);
        pulse(1);
        repeat (40) @(negedge clk);

        // level held high for 20 cycles yields one placement only
        randX = 4'h7; randY = 4'h2;
        push(8'h72, 5);
        @(negedge clk);
        goodColl = 1'b1;
        t_drive = cyc;
        chk_evt = 1'b1;
        repeat (20) @(negedge clk);
        goodColl = 1'b0;
        repeat (10) @(negedge clk);

        // two further edges during a placement give exactly one extra placement
        randX = 4'h3; randY = 4'h9;
        push(8'h39, 5);
        push(8'h39, 5);
        pulse(1);
        pulse(0);
        pulse(0);
        repeat (25) @(negedge clk);

        // empty body commits straight after LOAD
        body_len = 6'd0;
        randX = 4'h3; randY = 4'h3;
        push(8'h33, 2);
        pulse(1);
        repeat (10) @(negedge clk);

        // reset during SCAN with a pending event: everything discarded
        body_len = 6'd3;
        randX = 4'h5; randY = 4'h5;
        pulse(1);
        pulse(0);
        repeat (3) @(negedge clk);
        chk("mid_busy", busy, 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_cord", apple_cord, 8'hC5);
        chk("mid_rst_valid", apple_valid, 1);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        chk("after_rst_cord", apple_cord, 8'hC5);
        chk("after_rst_busy", busy, 0);

        chk("sb_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/apple_placer.md
# apple_placer

Sequential controller that places a new apple after each good collision. It samples the random coordinate source, scans the snake body serially one segment per cycle, and re-samples until it finds a free cell. Once a free cell is found, it commits the coordinate and drives the per-pixel apple flag to the display path. It sits between the collision logic, the LFSR coordinate source, the body register array and the pixel renderer.

## Interface
- BODY_MAX, 50, number of body entries in the body array
- MAX_TRIES, 8, random samples attempted before switching to deterministic sweep
- RESET_CORD, 8'hC5, apple coordinate {x,y} after reset
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- goodColl  in  1  head-on-apple collision level from collision logic; asynchronous to placement, synchronized internally
- randX, randY  in  4 each  random candidate column/row
- body  in  BODY_MAX x 8  packed {x,y} per segment, entry 0 = head
- body_len  in  6  number of valid body entries, 0..BODY_MAX; entries at index >= body_len are ignored
- x, y  in  4 each  pixel currently being drawn
- apple  out  1  registered: pixel {x,y} equals apple_cord and apple_valid
- apple_cord  out  8  committed apple coordinate {x,y}
- apple_valid  out  1  apple present on board
- busy  out  1  placement in progress (state != IDLE)
- place_done  out  1  one-cycle pulse when a new coordinate commits

## Operation
- Event detect: goodColl passes through two flops (s1, s2) and then a third (s3). The event pulse is s2 & ~s3. There is exactly one event per rising edge of goodColl, regardless of how long goodColl stays high.
- FSM states: IDLE, LOAD, SCAN, COMMIT.
- IDLE: on event (or pending flag), go to LOAD, clear pending, set apple_valid=0.
- LOAD: capture the candidate coordinate, set idx=0, and increment tries (saturating at MAX_TRIES).
  - The candidate is {randX,randY} while tries < MAX_TRIES.
  - Otherwise the candidate is the previous candidate + 1, mod 256 (sweep).
  - If body_len==0, go directly to COMMIT; else go to SCAN.
- SCAN: compare cand with body[idx].
  - Match: go to LOAD (abort remaining scan).
  - No match and idx==body_len-1: go to COMMIT.
  - Otherwise: idx++.
- COMMIT: apple_cord<=cand, apple_valid<=1, place_done<=1, tries<=0, then go to IDLE.
- Sweep guarantees termination: body_len <= 50 < 256 cells.
- Event during a non-IDLE state sets a one-deep pending flag. Further events while pending is set are dropped. Pending is serviced on the cycle after returning to IDLE.
- body and body_len must be stable while busy; this is the caller's responsibility and is not checked.
- apple: registered, apple <= apple_valid & ({x,y}==apple_cord).

## Timing
- Reset values:
  - state=IDLE, s1=s2=s3=0, pending=0, tries=0, idx=0, cand=0
  - apple_cord=RESET_CORD, apple_valid=1, apple=0, busy=0, place_done=0
- Event pulse: high 3 cycles after the first sampled-high goodColl edge.
- Cycle numbering below takes E = the event pulse cycle.
  - LOAD at E+1.
  - SCAN at E+2 .. E+1+body_len.
  - COMMIT at E+2+body_len.
  - place_done and the new apple_cord are visible at E+3+body_len, assuming no hit.
- Each hit adds (hit index + 2) cycles: the partial scan plus a new LOAD.
- body_len==0: COMMIT at E+2, outputs updated at E+3.
- busy is high from E+1 through the COMMIT cycle inclusive.
- apple lags {x,y} by 1 cycle and is 0 whenever apple_valid=0.
- Reset asserted mid-placement: immediately returns to all reset values, and any pending event is discarded.

## Test plan
- Reset: hold reset low, then release. Require apple_cord=8'hC5, apple_valid=1, and busy=0. Drive x=4'hC, y=4'h5: apple=1 on the next cycle. Drive x=4'hC, y=4'h4: apple=0.
- Free cell:
  - Setup: body_len=3, body[0..2]=8'h11,8'h12,8'h13, randX=4'h7, randY=4'h2.
  - Stimulus: pulse goodColl.
  - Required: place_done at E+6 and apple_cord=8'h72. apple_valid is 0 between E+1 and E+5.
- Collision then retry:
  - Setup: randX/randY=8'h12 on the first LOAD, 8'h40 on the second.
  - Required: cand 8'h12 hits at idx 1, then LOAD again. Commit 8'h40. place_done at E+9.
- Sweep:
  - Setup: randX/randY held at 8'h11, which equals body[0].
  - Required: 8 LOADs hit. Sweep candidates 8'h12 and 8'h13 also hit. Commit 8'h14.
- Events:
  - Hold goodColl high for 20 cycles: exactly one placement.
  - Two edges during a placement: exactly one extra placement follows.
  - body_len=0: commit at E+3.
- Reset mid-operation: assert reset during SCAN. Require immediate apple_cord=8'hC5, apple_valid=1, busy=0, and no later place_done.
